// File: rtl/fb_pkg.sv
// Shared constants, types and helpers for the 160x120 pixel framebuffer sink.
// Addresses are column-major (x*120 + y), matching the fillscreen order.
package fb_pkg;

    localparam logic [7:0]  SCREEN_W = 8'd160;
    localparam logic [6:0]  SCREEN_H = 7'd120;
    localparam logic [14:0] FB_DEPTH = 15'd19200;
    localparam logic [14:0] FB_LAST  = 15'd19199;

    typedef logic [14:0] fb_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } fb_state_t;

    function automatic fb_addr_t xy_to_addr(input logic [7:0] x, input logic [6:0] y);
        return fb_addr_t'(x) * fb_addr_t'(SCREEN_H) + fb_addr_t'(y);
    endfunction

    function automatic logic xy_in_bounds(input logic [7:0] x, input logic [6:0] y);
        return (x < SCREEN_W) && (y < SCREEN_H);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module fb_ram
    import fb_pkg::*;
#(
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                we,
    input  fb_addr_t            waddr,
    input  logic [COLOUR_W-1:0] wdata,
    input  logic                re,
    input  fb_addr_t            raddr,
    output logic [COLOUR_W-1:0] rdata
);

    logic [COLOUR_W-1:0] mem [0:int'(FB_DEPTH)-1];

    // NOTE: the array and its read register have no reset so the tools can map
    // them onto block RAM; contents start at the configuration value of zero.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pixel_fb_sink.sv
// Captures in-bounds VGA plots into the framebuffer, counts accepted and dropped
// plots, and offers a random-access read port plus a full-frame raster scanout.
module pixel_fb_sink
    import fb_pkg::*;
#(
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          vga_x,
    input  logic [6:0]          vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                vga_plot,
    input  logic                rd_en,
    input  logic [7:0]          rd_x,
    input  logic [6:0]          rd_y,
    output logic                rd_valid,
    output logic [COLOUR_W-1:0] rd_colour,
    input  logic                scan_start,
    output logic                scan_valid,
    output logic [7:0]          scan_x,
    output logic [6:0]          scan_y,
    output logic [COLOUR_W-1:0] scan_colour,
    output logic                scan_done,
    output logic [14:0]         plot_count,
    output logic [14:0]         oob_count
);

    fb_state_t state_q, state_d;

    fb_addr_t   scan_addr_q;
    logic [7:0] scan_xc_q;
    logic [6:0] scan_yc_q;

    logic                plot_ok, plot_oob;
    logic                rd_in_range, rd_accept;
    logic                ram_re;
    fb_addr_t            ram_raddr;
    logic [COLOUR_W-1:0] ram_rdata;

    logic rd_valid_q, rd_oob_q, scan_valid_q, scan_done_q;
    logic [7:0]  scan_x_q;
    logic [6:0]  scan_y_q;
    logic [14:0] plot_count_q, oob_count_q;

    assign plot_ok     = vga_plot &&  xy_in_bounds(vga_x, vga_y);
    assign plot_oob    = vga_plot && !xy_in_bounds(vga_x, vga_y);
    assign rd_in_range = xy_in_bounds(rd_x, rd_y);
    // A scan request wins over a simultaneous random read.
    assign rd_accept   = (state_q == IDLE) && rd_en && !scan_start;

    assign ram_re    = (state_q == SCAN) || (rd_accept && rd_in_range);
    assign ram_raddr = (state_q == SCAN) ? scan_addr_q : xy_to_addr(rd_x, rd_y);

    fb_ram #(.COLOUR_W(COLOUR_W)) u_ram (
        .clk   (clk),
        .we    (plot_ok),
        .waddr (xy_to_addr(vga_x, vga_y)),
        .wdata (vga_colour),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is defaulted before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scan_start) state_d = SCAN;
            SCAN:    if (scan_addr_q == FB_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Scan position walks y-inner, x-outer, so the flat address simply increments.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != SCAN) begin
            scan_addr_q <= '0;
            scan_xc_q   <= '0;
            scan_yc_q   <= '0;
        end else begin
            scan_addr_q <= scan_addr_q + 15'd1;
            if (scan_yc_q == SCREEN_H - 7'd1) begin
                scan_yc_q <= '0;
                scan_xc_q <= scan_xc_q + 8'd1;
            end else begin
                scan_yc_q <= scan_yc_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q   <= 1'b0;
            rd_oob_q     <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            scan_done_q  <= 1'b0;
            plot_count_q <= '0;
            oob_count_q  <= '0;
        end else begin
            rd_valid_q   <= rd_accept;
            rd_oob_q     <= !rd_in_range;
            scan_valid_q <= (state_q == SCAN);
            scan_x_q     <= scan_xc_q;
            scan_y_q     <= scan_yc_q;
            scan_done_q  <= (state_q == DONE);
            if (plot_ok && plot_count_q != '1) begin
                plot_count_q <= plot_count_q + 15'd1;
            end
            if (plot_oob && oob_count_q != '1) begin
                oob_count_q <= oob_count_q + 15'd1;
            end
        end
    end

    // The RAM output register is unreset, so data is masked until a beat is valid.
    assign rd_valid    = rd_valid_q;
    assign rd_colour   = (rd_valid_q && !rd_oob_q) ? ram_rdata : '0;
    assign scan_valid  = scan_valid_q;
    assign scan_x      = scan_x_q;
    assign scan_y      = scan_y_q;
    assign scan_colour = scan_valid_q ? ram_rdata : '0;
    assign scan_done   = scan_done_q;
    assign plot_count  = plot_count_q;
    assign oob_count   = oob_count_q;

endmodule

// File: tb/tb_pixel_fb_sink.sv
// Scoreboard bench for pixel_fb_sink: directed plots, reads and scans, with
// read responses and scan beats checked by monitors on the falling edge.
module tb_pixel_fb_sink;

    localparam int COLOUR_W = 3;
    localparam int NPIX     = 19200;

    logic                clk;
    logic                rst_n;
    logic [7:0]          vga_x;
    logic [6:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                rd_en;
    logic [7:0]          rd_x;
    logic [6:0]          rd_y;
    logic                rd_valid;
    logic [COLOUR_W-1:0] rd_colour;
    logic                scan_start;
    logic                scan_valid;
    logic [7:0]          scan_x;
    logic [6:0]          scan_y;
    logic [COLOUR_W-1:0] scan_colour;
    logic                scan_done;
    logic [14:0]         plot_count;
    logic [14:0]         oob_count;

    pixel_fb_sink #(.COLOUR_W(COLOUR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .rd_en       (rd_en),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_valid    (rd_valid),
        .rd_colour   (rd_colour),
        .scan_start  (scan_start),
        .scan_valid  (scan_valid),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .scan_colour (scan_colour),
        .scan_done   (scan_done),
        .plot_count  (plot_count),
        .oob_count   (oob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [COLOUR_W-1:0] rd_exp_q [$];
    logic [COLOUR_W-1:0] model [0:NPIX-1];

    int sc_beats, coord_bad, colour_bad, gap_bad;
    bit sc_prev;
    int first_x, first_y, first_c, last_x, last_y, last_c;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        rd_en = 1'b0; rd_x = '0; rd_y = '0; scan_start = 1'b0;
    endtask

    task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [COLOUR_W-1:0] c);
        vga_x = x; vga_y = y; vga_colour = c; vga_plot = 1'b1;
        if (x < 8'd160 && y < 7'd120) model[int'(x) * 120 + int'(y)] = c;
        tick();
        vga_plot = 1'b0;
    endtask

    task automatic rd(input logic [7:0] x, input logic [6:0] y, input logic [COLOUR_W-1:0] expv);
        rd_en = 1'b1; rd_x = x; rd_y = y;
        rd_exp_q.push_back(expv);
        tick();
        check("rd_valid_latency", int'(rd_valid), 1);
        rd_en = 1'b0;
    endtask

    // Read-port scoreboard and scan monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            sc_beats = 0; sc_prev = 1'b0;
            coord_bad = 0; colour_bad = 0; gap_bad = 0;
        end else begin
            if (rd_valid) begin
                if (rd_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got rd_valid with colour %0d, expected no response", rd_colour);
                end else begin
                    check("rd_colour", int'(rd_colour), int'(rd_exp_q.pop_front()));
                end
            end
            if (scan_valid) begin
                if (sc_beats == 0) begin
                    first_x = int'(scan_x); first_y = int'(scan_y); first_c = int'(scan_colour);
                end
                if (sc_beats == NPIX - 1) begin
                    last_x = int'(scan_x); last_y = int'(scan_y); last_c = int'(scan_colour);
                end
                if (int'(scan_x) != sc_beats / 120 || int'(scan_y) != sc_beats % 120) coord_bad++;
                if (sc_beats < NPIX && scan_colour !== model[sc_beats]) colour_bad++;
                sc_beats++;
            end else if (sc_prev && sc_beats != NPIX) begin
                gap_bad++;
            end
            if (scan_done) begin
                check("scan_beats", sc_beats, NPIX);
                check("scan_done_follows_last_beat", int'(sc_prev), 1);
                check("scan_coord_errors", coord_bad, 0);
                check("scan_colour_errors", colour_bad, 0);
                check("scan_gaps", gap_bad, 0);
                sc_beats = 0; coord_bad = 0; colour_bad = 0; gap_bad = 0;
            end
            sc_prev = scan_valid;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int stray;
        for (int i = 0; i < NPIX; i++) model[i] = '0;
        idle_inputs();
        rst_n = 1'b0;

        // Reset with random inputs; plots kept out of range.
        repeat (2) begin
            vga_x = 8'($urandom_range(160, 255)); vga_y = 7'($urandom);
            vga_colour = COLOUR_W'($urandom); vga_plot = 1'($urandom);
            rd_en = 1'($urandom); rd_x = 8'($urandom); rd_y = 7'($urandom);
            scan_start = 1'($urandom);
            tick();
        end
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_colour", int'(rd_colour), 0);
        check("rst_scan_valid", int'(scan_valid), 0);
        check("rst_scan_x", int'(scan_x), 0);
        check("rst_scan_y", int'(scan_y), 0);
        check("rst_scan_colour", int'(scan_colour), 0);
        check("rst_scan_done", int'(scan_done), 0);
        check("rst_plot_count", int'(plot_count), 0);
        check("rst_oob_count", int'(oob_count), 0);
        idle_inputs();
        rst_n = 1'b1;
        tick();

        // Basic plot and read-back.
        plot(8'd10, 7'd20, 3'd5);
        rd(8'd10, 7'd20, 3'd5);
        check("plot_count_one", int'(plot_count), 1);

        // Out-of-bounds plots are dropped and counted.
        plot(8'd160, 7'd0, 3'd7);
        plot(8'd3, 7'd120, 3'd2);
        check("oob_count_two", int'(oob_count), 2);
        check("plot_count_unchanged", int'(plot_count), 1);
        rd(8'd0, 7'd0, 3'd0);
        rd(8'd200, 7'd5, 3'd0);
        rd(8'd10, 7'd20, 3'd5);
        rd(8'd3, 7'd120, 3'd0);

        // Same-cycle write and read return the old value.
        vga_x = 8'd5; vga_y = 7'd5; vga_colour = 3'd6; vga_plot = 1'b1;
        model[5 * 120 + 5] = 3'd6;
        rd_en = 1'b1; rd_x = 8'd5; rd_y = 7'd5;
        rd_exp_q.push_back(3'd0);
        tick();
        check("collision_rd_valid", int'(rd_valid), 1);
        idle_inputs();
        rd(8'd5, 7'd5, 3'd6);

        // Full scan with corner pixels; a simultaneous rd_en is dropped.
        plot(8'd0, 7'd0, 3'd3);
        plot(8'd159, 7'd119, 3'd7);
        scan_start = 1'b1; rd_en = 1'b1; rd_x = 8'd10; rd_y = 7'd20;
        tick();
        idle_inputs();
        check("scan_not_yet_valid", int'(scan_valid), 0);
        tick();
        check("scan_first_beat_valid", int'(scan_valid), 1);
        repeat (50) tick();
        rd_en = 1'b1; rd_x = 8'd10; rd_y = 7'd20; scan_start = 1'b1;
        tick();
        idle_inputs();
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            tick();
            if (scan_done) found = 1'b1;
        end
        check("scan_done_seen", int'(found), 1);
        check("scan_valid_low_at_done", int'(scan_valid), 0);
        tick();
        check("scan_done_single_pulse", int'(scan_done), 0);
        stray = 0;
        repeat (5) begin
            tick();
            if (scan_valid || scan_done) stray++;
        end
        check("no_second_scan", stray, 0);
        check("first_beat_x", first_x, 0);
        check("first_beat_y", first_y, 0);
        check("first_beat_colour", first_c, 3);
        check("last_beat_x", last_x, 159);
        check("last_beat_y", last_y, 119);
        check("last_beat_colour", last_c, 7);
        check("plot_count_after_scan", int'(plot_count), 4);

        // Reset in the middle of a scan.
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (scan_valid) found = 1'b1;
        end
        check("scan2_started", int'(found), 1);
        repeat (100) tick();
        rst_n = 1'b0;
        tick();
        check("midscan_rst_scan_valid", int'(scan_valid), 0);
        check("midscan_rst_scan_done", int'(scan_done), 0);
        check("midscan_rst_plot_count", int'(plot_count), 0);
        check("midscan_rst_oob_count", int'(oob_count), 0);
        rst_n = 1'b1;
        stray = 0;
        repeat (20) begin
            tick();
            if (scan_valid || scan_done) stray++;
        end
        check("no_scan_after_reset", stray, 0);
        rd(8'd0, 7'd0, 3'd3);

        // Drop counter saturates instead of wrapping.
        vga_x = 8'd200; vga_y = 7'd0; vga_colour = 3'd1; vga_plot = 1'b1;
        repeat (32770) tick();
        vga_plot = 1'b0;
        tick();
        check("oob_count_saturated", int'(oob_count), 32767);
        check("plot_count_after_sat", int'(plot_count), 0);

        repeat (3) tick();
        check("rd_scoreboard_drained", rd_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
